dram_req_arbiter: RTL and testbench
===================================

DRAM_REQ_ARBITER -- requirements
Module: dram_req_arbiter

Interface
REQ-001 Parameters SHALL be as follows.
- NUM_REQ, default 4: number of requesters.
- ADDR_W, default 58: cache-line address width.
- TAG_W, default 6: read-number tag width (READ_NUM_WIDTH).
- MAX_OUT, default 16: maximum in-flight k/l pairs (power of 2).
REQ-002 Ports SHALL be as follows (name, direction, width, meaning).
- CLK_200M, in, 1: the single clock.
- spl_reset, in, 1: reset, synchronous, active-high.
- req_valid, in, NUM_REQ: per-requester pair request.
- req_ready, out, NUM_REQ: one-hot grant; a request is accepted when valid and ready are both high.
- req_addr_k, in, NUM_REQ*ADDR_W: k address, requester i at slice i.
- req_addr_l, in, NUM_REQ*ADDR_W: l address.
- req_tag, in, NUM_REQ*TAG_W: read-number tag.
- stall, in, 1: downstream almost-full.
- drain_req, in, 1: stop granting and empty the pipe.
- out_valid, out, 1: pair-issue strobe to the 2-write request FIFO.
- out_addr_k, out, ADDR_W: issued k address.
- out_addr_l, out, ADDR_W: issued l address.
- out_tag, out, TAG_W: issued tag.
- rsp_valid, in, 1: matched k/l response pair present.
- rsp_cl_k, in, 512: k response line.
- rsp_cl_l, in, 512: l response line.
- rsp_route, out, NUM_REQ: one-hot response delivery.
- rsp_k_out, out, 512: routed k line.
- rsp_l_out, out, 512: routed l line.
- rsp_tag_out, out, TAG_W: tag of the routed pair.
- outstanding, out, log2(MAX_OUT)+1: in-flight pair count.
- drain_done, out, 1: pipe empty while draining.
- err_unexp, out, 1: sticky; response arrived with nothing outstanding.

Function
REQ-003 Grant SHALL be round-robin: the search starts at the requester after the last granted one; the pointer advances only on acceptance.
REQ-004 req_ready SHALL be combinational and asserted for at most one requester, only when state=RUN, stall=0 and outstanding<MAX_OUT.
REQ-005 An accepted request SHALL appear on out_valid/out_addr_k/out_addr_l/out_tag exactly 1 cycle later (registered); out_valid SHALL be 0 otherwise.
REQ-006 Each acceptance SHALL push {requester id, tag} into an in-order tracking FIFO of depth MAX_OUT.
REQ-007 On rsp_valid with a non-empty tracking FIFO, the block SHALL pop the head and, 1 cycle later, assert rsp_route one-hot at the stored id with rsp_k_out, rsp_l_out and rsp_tag_out registered.
REQ-008 outstanding SHALL increment on acceptance and decrement on a routed response; with both in the same cycle it SHALL hold.
REQ-009 When outstanding=MAX_OUT, no grant SHALL occur; a response in that cycle frees the credit from the next cycle onward.
REQ-010 rsp_valid with an empty FIFO SHALL be dropped (no rsp_route) and SHALL set err_unexp until reset.
REQ-011 The FSM SHALL have states RUN, DRAIN and DONE.
- RUN -> DRAIN when drain_req=1 (no grant in that cycle).
- DRAIN -> DONE when outstanding=0.
- DONE -> RUN when drain_req=0.
- drain_done=1 only in DONE.
REQ-012 stall SHALL block new grants only; a response already in flight SHALL still be routed.
REQ-013 Tracking-FIFO pointers SHALL wrap modulo MAX_OUT; full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-014 spl_reset SHALL act on the clock edge.
- state=RUN; RR pointer selects requester 0 first; FIFO empty.
- outstanding=0; err_unexp=0; out_valid=0; rsp_route=0.
- Data outputs = 0.
REQ-015 Reset mid-operation SHALL discard all in-flight tracking; responses arriving afterwards SHALL set err_unexp.

Structure
REQ-016 ADDR_W, TAG_W and CL_W=512 SHALL live in the shared package smem_pkg.
REQ-017 The tracking FIFO SHALL be the sub-module dram_req_order_fifo (synchronous, one write port, one read port, first-word-fall-through).

Verification
REQ-018 All four requesters valid continuously, no stall -> grants 0,1,2,3,0 on consecutive cycles; out_valid 1 cycle after each.
REQ-019 Issue 16 pairs with no responses -> outstanding=16 and req_ready=0; one rsp_valid -> 1 grant on the following cycle.
REQ-020 Requesters 2, 0, 3 accepted, then 3 responses -> rsp_route=0100, then 0001, then 1000, with matching tags.
REQ-021 Acceptance and rsp_valid in the same cycle at outstanding=5 -> outstanding stays 5.
REQ-022 rsp_valid after reset with an empty FIFO -> no rsp_route; err_unexp=1.
REQ-023 drain_req with 3 outstanding, stall=1 -> no grants; drain_done=1 the cycle after the 3rd response; drain_req low -> RUN.

Source files
------------

// File: rtl/smem_pkg.sv
// Shared memory-subsystem constants and types for the DRAM request path.
// Contents: address/tag/cache-line widths, arbiter state encoding and a
// pointer-width helper used by the in-order tracking FIFO.
package smem_pkg;

   localparam int ADDR_W = 58;
   localparam int TAG_W  = 6;
   localparam int CL_W   = 512;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } arb_state_t;

   // Address width of a power-of-2 FIFO, never below 1 so slices stay legal.
   function automatic int fifo_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dram_req_order_fifo.sv
// In-order tracking FIFO, first-word-fall-through: rd_data always shows the
// head entry while empty is low.
// Ports: CLK_200M clock, spl_reset sync active-high reset, wr_en/wr_data
// push, rd_en pop, rd_data head word, empty/full status.
module dram_req_order_fifo
   import smem_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic         CLK_200M,
   input  logic         spl_reset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         empty,
   output logic         full
);

   localparam int AW = fifo_aw(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   // Pointers carry one extra wrap bit: equal low bits with differing wrap
   // bits means full, fully equal means empty.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge CLK_200M) begin
      if (spl_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (rd_en && !empty) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge CLK_200M) begin
      if (wr_en && !full) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/dram_req_arbiter.sv
// Round-robin arbiter issuing k/l read pairs to the DRAM request FIFO and
// routing matched k/l responses back to the originating requester in order.
// Ports: CLK_200M clock, spl_reset sync active-high reset; req_* per-requester
// request bus with one-hot req_ready grant; stall/drain_req flow control;
// out_* registered issue bus; rsp_valid/rsp_cl_k/rsp_cl_l response input;
// rsp_route/rsp_k_out/rsp_l_out/rsp_tag_out registered delivery; outstanding
// in-flight count, drain_done, sticky err_unexp.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RUN   | normal operation, grants allowed
//   ST_DRAIN | no grants, waiting for all in-flight pairs to return
//   ST_DONE  | pipe empty, drain_done high until drain_req drops
module dram_req_arbiter
   import smem_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = smem_pkg::ADDR_W,
   parameter int TAG_W   = smem_pkg::TAG_W,
   parameter int MAX_OUT = 16,
   localparam int OUT_W  = $clog2(MAX_OUT) + 1
) (
   input  logic                       CLK_200M,
   input  logic                       spl_reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_k,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_l,
   input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
   input  logic                       stall,
   input  logic                       drain_req,
   output logic                       out_valid,
   output logic [ADDR_W-1:0]          out_addr_k,
   output logic [ADDR_W-1:0]          out_addr_l,
   output logic [TAG_W-1:0]           out_tag,
   input  logic                       rsp_valid,
   input  logic [CL_W-1:0]            rsp_cl_k,
   input  logic [CL_W-1:0]            rsp_cl_l,
   output logic [NUM_REQ-1:0]         rsp_route,
   output logic [CL_W-1:0]            rsp_k_out,
   output logic [CL_W-1:0]            rsp_l_out,
   output logic [TAG_W-1:0]           rsp_tag_out,
   output logic [OUT_W-1:0]           outstanding,
   output logic                       drain_done,
   output logic                       err_unexp
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int FW   = ID_W + TAG_W;

   arb_state_t         state;
   logic [ID_W-1:0]    last_gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic [ID_W-1:0]    cand;
   logic               gnt_found;
   logic               can_grant;
   logic               pop;
   logic [FW-1:0]      fifo_wdata;
   logic [FW-1:0]      fifo_rdata;
   logic               fifo_empty;
   logic               fifo_full;
   logic [ID_W-1:0]    head_id;
   logic [TAG_W-1:0]   head_tag;
   logic [OUT_W-1:0]   outstanding_nxt;

   // drain_req blocks the grant in the same cycle it is seen, not one later.
   assign can_grant = (state == ST_RUN) && !drain_req && !stall && !fifo_full
                      && (outstanding < OUT_W'(MAX_OUT));

   // Search begins one past the last granted requester.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      req_ready = '0;
      if (can_grant) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_gnt) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
               gnt_found = 1'b1;
               gnt_idx   = cand;
            end
         end
      end
      if (gnt_found) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   assign pop        = rsp_valid && !fifo_empty;
   assign fifo_wdata = {gnt_idx, req_tag[gnt_idx*TAG_W +: TAG_W]};
   assign head_id    = fifo_rdata[FW-1 -: ID_W];
   assign head_tag   = fifo_rdata[TAG_W-1:0];

   always_comb begin
      outstanding_nxt = outstanding;
      if (gnt_found && !pop) begin
         outstanding_nxt = outstanding + OUT_W'(1);
      end else if (!gnt_found && pop) begin
         outstanding_nxt = outstanding - OUT_W'(1);
      end
   end

   dram_req_order_fifo #(
      .DEPTH (MAX_OUT),
      .W     (FW)
   ) u_order_fifo (
      .CLK_200M (CLK_200M),
      .spl_reset(spl_reset),
      .wr_en    (gnt_found),
      .wr_data  (fifo_wdata),
      .rd_en    (pop),
      .rd_data  (fifo_rdata),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   always_ff @(posedge CLK_200M) begin
      if (spl_reset) begin
         state       <= ST_RUN;
         last_gnt    <= ID_W'(NUM_REQ - 1);
         outstanding <= '0;
         err_unexp   <= 1'b0;
         drain_done  <= 1'b0;
         out_valid   <= 1'b0;
         out_addr_k  <= '0;
         out_addr_l  <= '0;
         out_tag     <= '0;
         rsp_route   <= '0;
         rsp_k_out   <= '0;
         rsp_l_out   <= '0;
         rsp_tag_out <= '0;
      end else begin
         outstanding <= outstanding_nxt;

         out_valid <= gnt_found;
         if (gnt_found) begin
            last_gnt   <= gnt_idx;
            out_addr_k <= req_addr_k[gnt_idx*ADDR_W +: ADDR_W];
            out_addr_l <= req_addr_l[gnt_idx*ADDR_W +: ADDR_W];
            out_tag    <= req_tag[gnt_idx*TAG_W +: TAG_W];
         end

         rsp_route <= '0;
         if (pop) begin
            rsp_route   <= NUM_REQ'(1) << head_id;
            rsp_k_out   <= rsp_cl_k;
            rsp_l_out   <= rsp_cl_l;
            rsp_tag_out <= head_tag;
         end
         if (rsp_valid && fifo_empty) begin
            err_unexp <= 1'b1;
         end

         // DRAIN looks at the post-update count so drain_done rises the
         // cycle right after the last response is popped.
         case (state)
            ST_RUN: begin
               if (drain_req) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (outstanding_nxt == '0) begin
                  state      <= ST_DONE;
                  drain_done <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!drain_req) begin
                  state      <= ST_RUN;
                  drain_done <= 1'b0;
               end
            end
            default: begin
               state      <= ST_RUN;
               drain_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_req_arbiter.sv
module tb_dram_req_arbiter;
   import smem_pkg::*;

   localparam int NR = 4;
   localparam int AW = 58;
   localparam int TW = 6;
   localparam int MO = 16;
   localparam int OW = 5;
   localparam int CW = CL_W;

   logic              CLK_200M;
   logic              spl_reset;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*AW-1:0]  req_addr_k;
   logic [NR*AW-1:0]  req_addr_l;
   logic [NR*TW-1:0]  req_tag;
   logic              stall;
   logic              drain_req;
   logic              out_valid;
   logic [AW-1:0]     out_addr_k;
   logic [AW-1:0]     out_addr_l;
   logic [TW-1:0]     out_tag;
   logic              rsp_valid;
   logic [CW-1:0]     rsp_cl_k;
   logic [CW-1:0]     rsp_cl_l;
   logic [NR-1:0]     rsp_route;
   logic [CW-1:0]     rsp_k_out;
   logic [CW-1:0]     rsp_l_out;
   logic [TW-1:0]     rsp_tag_out;
   logic [OW-1:0]     outstanding;
   logic              drain_done;
   logic              err_unexp;

   dram_req_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .TAG_W(TW), .MAX_OUT(MO)
   ) dut (
      .CLK_200M   (CLK_200M),
      .spl_reset  (spl_reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr_k (req_addr_k),
      .req_addr_l (req_addr_l),
      .req_tag    (req_tag),
      .stall      (stall),
      .drain_req  (drain_req),
      .out_valid  (out_valid),
      .out_addr_k (out_addr_k),
      .out_addr_l (out_addr_l),
      .out_tag    (out_tag),
      .rsp_valid  (rsp_valid),
      .rsp_cl_k   (rsp_cl_k),
      .rsp_cl_l   (rsp_cl_l),
      .rsp_route  (rsp_route),
      .rsp_k_out  (rsp_k_out),
      .rsp_l_out  (rsp_l_out),
      .rsp_tag_out(rsp_tag_out),
      .outstanding(outstanding),
      .drain_done (drain_done),
      .err_unexp  (err_unexp)
   );

   initial CLK_200M = 1'b0;
   always #5 CLK_200M = ~CLK_200M;

   // Reference model: requests in flight as an ordered list, plus the
   // round-robin "last served" requester and a coarse mode (0 run, 1 drain,
   // 2 done).
   int            n_cmp = 0;
   int            n_bad = 0;
   int            m_last;
   int            m_mode;
   bit            m_err;
   int            q_id[$];
   logic [TW-1:0] q_tag[$];
   logic [NR-1:0] obs_rdy;

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_cmp++;
      assert (act === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic rand_data();
      for (int i = 0; i < NR; i++) begin
         req_addr_k[i*AW +: AW] = AW'({$urandom(), $urandom()});
         req_addr_l[i*AW +: AW] = AW'({$urandom(), $urandom()});
         req_tag[i*TW +: TW]    = TW'($urandom());
      end
      for (int j = 0; j < CW/32; j++) begin
         rsp_cl_k[j*32 +: 32] = $urandom();
         rsp_cl_l[j*32 +: 32] = $urandom();
      end
   endtask

   task automatic do_reset();
      spl_reset = 1'b1;
      req_valid = '0;
      rsp_valid = 1'b0;
      stall     = 1'b0;
      drain_req = 1'b0;
      @(posedge CLK_200M);
      #1;
      spl_reset = 1'b0;
      m_last = NR - 1;
      m_mode = 0;
      m_err  = 1'b0;
      q_id.delete();
      q_tag.delete();
   endtask

   // One clock with the inputs currently driven; called at posedge+1.
   task automatic step();
      int            g;
      int            sz;
      bit            acc;
      bit            pop;
      int            hid;
      logic [TW-1:0] htag;
      logic [NR-1:0] exp_rdy;
      logic [AW-1:0] ek;
      logic [AW-1:0] el;
      logic [TW-1:0] et;
      logic [CW-1:0] ck;
      logic [CW-1:0] cl;
      #1;
      sz = q_id.size();
      g  = -1;
      if (m_mode == 0 && !drain_req && !stall && sz < MO) begin
         for (int k = 1; k <= NR; k++) begin
            if (g < 0 && req_valid[(m_last + k) % NR]) g = (m_last + k) % NR;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      obs_rdy = req_ready;
      chk("req_ready", CW'(req_ready), CW'(exp_rdy));
      acc = (g >= 0);
      ek = '0; el = '0; et = '0; hid = 0; htag = '0;
      if (acc) begin
         ek = req_addr_k[g*AW +: AW];
         el = req_addr_l[g*AW +: AW];
         et = req_tag[g*TW +: TW];
      end
      pop = rsp_valid && (sz > 0);
      if (pop) begin
         hid  = q_id[0];
         htag = q_tag[0];
      end
      ck = rsp_cl_k;
      cl = rsp_cl_l;
      @(posedge CLK_200M);
      if (pop) begin
         void'(q_id.pop_front());
         void'(q_tag.pop_front());
      end
      if (acc) begin
         q_id.push_back(g);
         q_tag.push_back(et);
         m_last = g;
      end
      if (rsp_valid && sz == 0) m_err = 1'b1;
      case (m_mode)
         0: if (drain_req) m_mode = 1;
         1: if (q_id.size() == 0) m_mode = 2;
         default: if (!drain_req) m_mode = 0;
      endcase
      #1;
      chk("out_valid", CW'(out_valid), CW'(acc));
      if (acc) begin
         chk("out_addr_k", CW'(out_addr_k), CW'(ek));
         chk("out_addr_l", CW'(out_addr_l), CW'(el));
         chk("out_tag", CW'(out_tag), CW'(et));
      end
      chk("rsp_route", CW'(rsp_route), pop ? CW'(NR'(1) << hid) : CW'(0));
      if (pop) begin
         chk("rsp_k_out", rsp_k_out, ck);
         chk("rsp_l_out", rsp_l_out, cl);
         chk("rsp_tag_out", CW'(rsp_tag_out), CW'(htag));
      end
      chk("outstanding", CW'(outstanding), CW'(q_id.size()));
      chk("drain_done", CW'(drain_done), CW'(m_mode == 2));
      chk("err_unexp", CW'(err_unexp), CW'(m_err));
   endtask

   initial begin
      logic [TW-1:0] t2, t0, t3;
      req_addr_k = '0; req_addr_l = '0; req_tag = '0;
      rsp_cl_k = '0; rsp_cl_l = '0;
      do_reset();

      // Reset state
      chk("rst_out_valid", CW'(out_valid), CW'(0));
      chk("rst_rsp_route", CW'(rsp_route), CW'(0));
      chk("rst_outstanding", CW'(outstanding), CW'(0));
      chk("rst_err", CW'(err_unexp), CW'(0));
      chk("rst_drain_done", CW'(drain_done), CW'(0));
      chk("rst_out_addr_k", CW'(out_addr_k), CW'(0));
      chk("rst_rsp_k_out", rsp_k_out, CW'(0));

      // Round-robin with all requesters valid
      req_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
         rand_data();
         step();
         chk("rr_seq", CW'(obs_rdy), CW'(NR'(1) << (i % NR)));
         chk("rr_out_valid", CW'(out_valid), CW'(1));
      end

      // Credit limit
      do_reset();
      req_valid = 4'hF;
      for (int i = 0; i < MO; i++) begin rand_data(); step(); end
      rand_data(); step();
      chk("full_outstanding", CW'(outstanding), CW'(MO));
      chk("full_ready", CW'(obs_rdy), CW'(0));
      rsp_valid = 1'b1; rand_data(); step();
      chk("full_ready_rsp_cycle", CW'(obs_rdy), CW'(0));
      rsp_valid = 1'b0; rand_data(); step();
      chk("grant_after_free", CW'(obs_rdy), CW'(4'b0001));
      req_valid = '0; rsp_valid = 1'b1;
      for (int i = 0; i < MO; i++) begin rand_data(); step(); end
      rsp_valid = 1'b0;

      // In-order routing 2, 0, 3
      do_reset();
      rand_data(); t2 = req_tag[2*TW +: TW]; req_valid = 4'b0100; step();
      rand_data(); t0 = req_tag[0*TW +: TW]; req_valid = 4'b0001; step();
      rand_data(); t3 = req_tag[3*TW +: TW]; req_valid = 4'b1000; step();
      req_valid = '0; rsp_valid = 1'b1;
      rand_data(); step();
      chk("route_a", CW'(rsp_route), CW'(4'b0100));
      chk("route_a_tag", CW'(rsp_tag_out), CW'(t2));
      rand_data(); step();
      chk("route_b", CW'(rsp_route), CW'(4'b0001));
      chk("route_b_tag", CW'(rsp_tag_out), CW'(t0));
      rand_data(); step();
      chk("route_c", CW'(rsp_route), CW'(4'b1000));
      chk("route_c_tag", CW'(rsp_tag_out), CW'(t3));
      rsp_valid = 1'b0;

      // Simultaneous accept and response at 5 outstanding
      do_reset();
      req_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin rand_data(); step(); end
      rsp_valid = 1'b1; rand_data(); step();
      chk("same_cycle_accept", CW'(out_valid), CW'(1));
      chk("same_cycle_hold", CW'(outstanding), CW'(5));
      req_valid = '0;
      for (int i = 0; i < 5; i++) begin rand_data(); step(); end
      rsp_valid = 1'b0;

      // Unexpected response after reset
      do_reset();
      rsp_valid = 1'b1; rand_data(); step();
      chk("unexp_route", CW'(rsp_route), CW'(0));
      chk("unexp_err", CW'(err_unexp), CW'(1));
      rsp_valid = 1'b0; step();
      chk("unexp_sticky", CW'(err_unexp), CW'(1));

      // Reset with pairs in flight discards them
      do_reset();
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) begin rand_data(); step(); end
      do_reset();
      rsp_valid = 1'b1; rand_data(); step();
      chk("midrst_route", CW'(rsp_route), CW'(0));
      chk("midrst_err", CW'(err_unexp), CW'(1));
      rsp_valid = 1'b0;

      // Drain with 3 outstanding under stall
      do_reset();
      req_valid = 4'hF;
      for (int i = 0; i < 3; i++) begin rand_data(); step(); end
      stall = 1'b1; drain_req = 1'b1;
      rand_data(); step();
      chk("drain_no_grant", CW'(obs_rdy), CW'(0));
      rsp_valid = 1'b1;
      rand_data(); step();
      rand_data(); step();
      chk("drain_not_done", CW'(drain_done), CW'(0));
      rand_data(); step();
      chk("drain_route_stalled", CW'(rsp_route), CW'(4'b0100));
      chk("drain_done_set", CW'(drain_done), CW'(1));
      rsp_valid = 1'b0; drain_req = 1'b0;
      rand_data(); step();
      chk("drain_done_clr", CW'(drain_done), CW'(0));
      stall = 1'b0;
      rand_data(); step();
      chk("run_after_drain", CW'(obs_rdy), CW'(4'b1000));

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rand_data();
         req_valid = NR'($urandom());
         stall     = ($urandom_range(0, 3) == 0);
         rsp_valid = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
         if (i == 300) do_reset();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
